// File: rtl/program_loader_pkg.sv
// ============================================================================
// program_loader_pkg : shared types and constants for the program loader
// Revision: 1.0
// ============================================================================
`default_nettype none

package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/loader_timeout_counter.sv
// ============================================================================
// loader_timeout_counter : idle-cycle counter that flags expiry at LIMIT cycles
// Revision: 1.0
// ============================================================================
`default_nettype none

module loader_timeout_counter #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Expiry names the edge on which the count would reach LIMIT; a clear wins.
    assign expire_o = enable_i && !clear_i && (count_q == W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// program_loader : framed byte stream to instruction-memory writer, CPU reset hold
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         ADDR_W         = 8,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [8:0]        bytes_loaded
);

    state_e            state_q, state_d;
    logic [8:0]        remaining_q, remaining_d;
    logic [7:0]        sum_q, sum_d;
    logic [8:0]        bytes_loaded_q, bytes_loaded_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              load_done_q, load_done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              w_accept;
    logic              w_in_frame;
    logic              w_expire;
    logic [7:0]        w_sum_next;

    assign w_accept   = in_valid && in_ready_q;
    assign w_in_frame = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign w_sum_next = sum_q + in_data;

    loader_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (w_accept || !w_in_frame),
        .enable_i (w_in_frame),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        sum_d          = sum_q;
        bytes_loaded_d = bytes_loaded_q;
        mem_write_d    = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        cpu_reset_d    = cpu_reset_q;
        err_code_d     = err_code_q;

        case (state_q)
            IDLE: begin
                if (w_accept && (in_data == SYNC_BYTE)) begin
                    state_d        = LEN;
                    cpu_reset_d    = 1'b1;
                    bytes_loaded_d = '0;
                end
            end
            LEN: begin
                if (w_accept) begin
                    remaining_d    = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    sum_d          = '0;
                    bytes_loaded_d = '0;
                    state_d        = DATA;
                end
            end
            DATA: begin
                if (w_accept) begin
                    mem_write_d    = 1'b1;
                    mem_addr_d     = ADDR_W'(bytes_loaded_q);
                    mem_wdata_d    = in_data;
                    sum_d          = w_sum_next;
                    bytes_loaded_d = bytes_loaded_q + 9'd1;
                    remaining_d    = remaining_q - 9'd1;
                    if (remaining_q == 9'd1) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (w_accept) begin
                    if (w_sum_next == 8'd0) begin
                        state_d     = DONE;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d    = ERR;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                if (w_accept && (in_data == SYNC_BYTE)) begin
                    state_d    = LEN;
                    err_code_d = ERR_NONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Expiry is never raised on an accepting cycle, so nothing above changed.
        if (w_expire && w_in_frame) begin
            state_d    = ERR;
            err_code_d = ERR_TIMEOUT;
        end

        in_ready_d  = (state_d != DONE);
        busy_d      = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
        load_done_d = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            sum_q          <= '0;
            bytes_loaded_q <= '0;
            in_ready_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            cpu_reset_q    <= 1'b1;
            busy_q         <= 1'b0;
            load_done_q    <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            sum_q          <= sum_d;
            bytes_loaded_q <= bytes_loaded_d;
            in_ready_q     <= in_ready_d;
            mem_write_q    <= mem_write_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            busy_q         <= busy_d;
            load_done_q    <= load_done_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign load_done    = load_done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign bytes_loaded = bytes_loaded_q;

endmodule

`default_nettype wire
